// File: rtl/poly_coeff_loader.sv
// rtl/poly_coeff_loader.sv - reduces a signed coefficient stream mod Q and writes it to the coefficient RAM
// Optional feature macro: ZERO_PAD_EN (zero-fill the RAM up to PAD_LEN words after the data).
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   start, base_addr     begin a load at base_addr; ignored while busy
//   in_valid, in_data    signed coefficient stream; in_ready marks acceptance
//   mem_we, mem_waddr,   RAM write port, driven one cycle after each transfer
//   mem_wdata
//   busy, done, err      load in progress, completion pulse, sticky out-of-range flag
module poly_coeff_loader #(
  parameter int Q             = 4591,
  parameter int N_COEF        = 757,
  parameter int IN_W          = 14,
  parameter int RAM_WIDTH     = 13,
  parameter int RAM_ADDR_BITS = 11
`ifdef ZERO_PAD_EN
  ,
  parameter int PAD_LEN       = 768
`endif
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [RAM_ADDR_BITS-1:0] base_addr,
  input  logic                     in_valid,
  input  logic [IN_W-1:0]          in_data,
  output logic                     in_ready,
  output logic                     mem_we,
  output logic [RAM_ADDR_BITS-1:0] mem_waddr,
  output logic [RAM_WIDTH-1:0]     mem_wdata,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

`ifdef ZERO_PAD_EN
  localparam int IDX_W = $clog2(PAD_LEN + 1);
`else
  localparam int IDX_W = $clog2(N_COEF + 1);
`endif
  // Two guard bits so both the input range and x+Q are representable.
  localparam int XW = IN_W + 2;

  localparam logic [IDX_W-1:0]     NUM_COEF  = IDX_W'(N_COEF);
  localparam logic [IDX_W-1:0]     LAST_COEF = IDX_W'(N_COEF - 1);
  localparam logic signed [XW-1:0] X_MAX     = XW'(Q - 1);
  localparam logic signed [XW-1:0] X_MIN     = XW'(1 - Q);
  localparam logic signed [XW-1:0] X_Q       = XW'(Q);

`ifdef ZERO_PAD_EN
  localparam logic [IDX_W-1:0]     LAST_PAD  = IDX_W'(PAD_LEN - 1);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FINISH, S_DONE, S_PAD} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FINISH, S_DONE} state_t;
`endif

  state_t                   state, next_state;
  logic [IDX_W-1:0]         idx;
  logic [RAM_ADDR_BITS-1:0] base_q;
  logic                     xfer;
  logic                     accept_start;
  logic signed [XW-1:0]     x_ext;
  logic [RAM_WIDTH-1:0]     red_data;
  logic                     x_bad;
`ifdef ZERO_PAD_EN
  logic                     pad_wr;
`endif

  assign x_ext = {{(XW-IN_W){in_data[IN_W-1]}}, in_data};

  always_comb begin
    red_data = '0;
    x_bad    = 1'b0;
    if (!x_ext[XW-1] && (x_ext <= X_MAX)) begin
      red_data = RAM_WIDTH'(x_ext);
    end else if (x_ext[XW-1] && (x_ext >= X_MIN)) begin
      red_data = RAM_WIDTH'(x_ext + X_Q);
    end else begin
      x_bad = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state   = state;
    in_ready     = 1'b0;
    xfer         = 1'b0;
    accept_start = 1'b0;
    busy         = (state != S_IDLE);
    // done coincides with the S_DONE cycle, which still counts as busy.
    done         = (state == S_DONE);
`ifdef ZERO_PAD_EN
    pad_wr       = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (start) begin
          accept_start = 1'b1;
          next_state   = S_LOAD;
        end
      end
      S_LOAD: begin
        in_ready = (idx < NUM_COEF);
        xfer     = in_valid & in_ready;
        if (xfer && (idx == LAST_COEF)) begin
`ifdef ZERO_PAD_EN
          next_state = (PAD_LEN > N_COEF) ? S_PAD : S_FINISH;
`else
          next_state = S_FINISH;
`endif
        end
      end
`ifdef ZERO_PAD_EN
      S_PAD: begin
        pad_wr = 1'b1;
        if (idx == LAST_PAD) next_state = S_FINISH;
      end
`endif
      // The final write is visible on the RAM port during S_FINISH.
      S_FINISH: next_state = S_DONE;
      S_DONE:   next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= '0;
      base_q    <= '0;
      mem_we    <= 1'b0;
      mem_waddr <= '0;
      mem_wdata <= '0;
      err       <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      if (accept_start) begin
        base_q <= base_addr;
        idx    <= '0;
        err    <= 1'b0;
      end
      if (xfer) begin
        mem_we    <= 1'b1;
        mem_waddr <= base_q + RAM_ADDR_BITS'(idx);
        mem_wdata <= red_data;
        idx       <= idx + IDX_W'(1);
        if (x_bad) err <= 1'b1;
      end
`ifdef ZERO_PAD_EN
      if (pad_wr) begin
        mem_we    <= 1'b1;
        mem_waddr <= base_q + RAM_ADDR_BITS'(idx);
        mem_wdata <= '0;
        idx       <= idx + IDX_W'(1);
      end
`endif
    end
  end

endmodule

// File: tb/tb_poly_coeff_loader.sv
// tb/tb_poly_coeff_loader.sv - self-checking bench for poly_coeff_loader
module tb_poly_coeff_loader;

  localparam int Q = 4591;
  localparam int N = 757;
`ifdef ZERO_PAD_EN
  localparam int PADN     = 768 - N;
  localparam int DONE_LAT = 12;
`else
  localparam int PADN     = 0;
  localparam int DONE_LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [10:0] base_addr = '0;
  logic        in_valid = 1'b0;
  logic [13:0] in_data = '0;
  logic        in_ready;
  logic        mem_we;
  logic [10:0] mem_waddr;
  logic [12:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        err;

  poly_coeff_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct { int addr; int data; } wr_t;
  typedef struct { int din; int dout; bit e; } vec_t;

  wr_t  exp_q[$];
  vec_t vt[12];
  int   vals[N];

  int total = 0;
  int bad = 0;
  int cyc_n = 0;
  int writes = 0;
  int dones = 0;
  int done_cyc = 0;
  int base_m = 0;
  int idx_m = 0;
  int last_xfer_cyc = 0;
  int ld_w = 0;
  int ld_d = 0;

  function automatic int ref_red(int x);
    if (x >= 0 && x <= Q - 1) return x;
    if (x < 0 && x >= -(Q - 1)) return x + Q;
    return 0;
  endfunction

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, exp, cyc_n);
    end
  endtask

  task automatic observe();
    wr_t w;
    if (mem_we) begin
      writes++;
      if (exp_q.size() == 0) begin
        chk("unexpected_write_addr", int'(mem_waddr), -1);
      end else begin
        w = exp_q.pop_front();
        chk("waddr", int'(mem_waddr), w.addr);
        chk("wdata", int'(mem_wdata), w.data);
      end
    end
    if (done) begin
      dones++;
      done_cyc = cyc_n;
    end
  endtask

  // Drive inputs for the next rising edge, predict any transfer, then sample after it.
  task automatic step(logic v, int d);
    in_valid = v;
    in_data  = d[13:0];
    if (v && in_ready && idx_m < N) begin
      exp_q.push_back('{addr: (base_m + idx_m) % 2048, data: ref_red(d)});
      idx_m++;
      last_xfer_cyc = cyc_n + 1;
      if (idx_m == N)
        for (int p = 0; p < PADN; p++)
          exp_q.push_back('{addr: (base_m + N + p) % 2048, data: 0});
    end
    @(negedge clk);
    cyc_n++;
    observe();
  endtask

  task automatic chk_zero_outputs(string tag);
    chk({tag, "_in_ready"}, int'(in_ready), 0);
    chk({tag, "_mem_we"}, int'(mem_we), 0);
    chk({tag, "_mem_waddr"}, int'(mem_waddr), 0);
    chk({tag, "_mem_wdata"}, int'(mem_wdata), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_err"}, int'(err), 0);
  endtask

  task automatic begin_load(int base);
    start     = 1'b1;
    base_addr = base[10:0];
    base_m    = base;
    idx_m     = 0;
    ld_w      = writes;
    ld_d      = dones;
    step(1'b0, 0);
    start = 1'b0;
    chk("busy_after_start", int'(busy), 1);
  endtask

  task automatic stream_rest(bit toggle);
    int g;
    logic v;
    g = 0;
    while (idx_m < N && g < 4 * N) begin
      v = toggle ? ((g % 2) == 0) : 1'b1;
      step(v, vals[idx_m]);
      g++;
    end
    if (idx_m < N) chk("load_timeout_transfers", idx_m, N);
  endtask

  task automatic finish_load();
    int g;
    int rdy_hi;
    g = 0;
    rdy_hi = 0;
    while (dones == ld_d && g < 40) begin
      if (in_ready) rdy_hi++;
      step(1'b1, 0);
      if (dones != ld_d) chk("busy_with_done", int'(busy), 1);
      g++;
    end
    chk("ready_after_last", rdy_hi, 0);
    chk("done_count", dones - ld_d, 1);
    chk("done_latency", done_cyc - last_xfer_cyc, DONE_LAT);
    chk("write_count", writes - ld_w, N + PADN);
    chk("queue_empty", exp_q.size(), 0);
    step(1'b0, 0);
    step(1'b0, 0);
    chk("done_single", dones - ld_d, 1);
    chk("busy_idle", int'(busy), 0);
  endtask

  initial begin
    vt[0]  = '{-1, 4590, 1'b0};
    vt[1]  = '{-4590, 1, 1'b0};
    vt[2]  = '{4590, 4590, 1'b0};
    vt[3]  = '{0, 0, 1'b0};
    vt[4]  = '{1, 1, 1'b0};
    vt[5]  = '{-4589, 2, 1'b0};
    vt[6]  = '{4589, 4589, 1'b0};
    vt[7]  = '{4591, 0, 1'b1};
    vt[8]  = '{-4591, 0, 1'b1};
    vt[9]  = '{8191, 0, 1'b1};
    vt[10] = '{-8192, 0, 1'b1};
    vt[11] = '{17, 17, 1'b1};

    #2 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_zero_outputs("reset");
    rst_n = 1'b1;
    step(1'b0, 0);
    step(1'b0, 0);

    // Basic load: 0..756 at base 0, valid held high.
    for (int k = 0; k < N; k++) vals[k] = k;
    begin_load(0);
    stream_rest(1'b0);
    finish_load();
    chk("basic_err", int'(err), 0);

    // Reduction and out-of-range table, then fill the rest of the load.
    for (int k = 0; k < N; k++) vals[k] = (k * 37) % Q;
    begin_load(5);
    for (int i = 0; i < 12; i++) begin
      step(1'b1, vt[i].din);
      chk("tbl_we", int'(mem_we), 1);
      chk("tbl_wdata", int'(mem_wdata), vt[i].dout);
      chk("tbl_err", int'(err), int'(vt[i].e));
    end
    stream_rest(1'b0);
    finish_load();
    chk("err_sticky_idle", int'(err), 1);

    // Wrap from 2000 with bubbles; the new start must clear err.
    for (int k = 0; k < N; k++) vals[k] = int'($urandom_range(0, 2 * (Q - 1))) - (Q - 1);
    begin_load(2000);
    chk("err_cleared_on_start", int'(err), 0);
    stream_rest(1'b1);
    finish_load();
    chk("wrap_err", int'(err), 0);

    // Ignored start mid-load, then asynchronous reset mid-load.
    for (int k = 0; k < N; k++) vals[k] = (k * 11) % Q;
    begin_load(300);
    while (idx_m < 300) step(1'b1, vals[idx_m]);
    start = 1'b1;
    base_addr = 11'd999;
    step(1'b1, vals[idx_m]);
    start = 1'b0;
    while (idx_m < 400) step(1'b1, vals[idx_m]);
    chk("busy_before_reset", int'(busy), 1);
    chk("queue_empty_before_reset", exp_q.size(), 0);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_zero_outputs("midload_reset");
    step(1'b0, 0);
    step(1'b0, 0);
    rst_n = 1'b1;
    ld_d = dones;
    ld_w = writes;
    for (int i = 0; i < 10; i++) step(1'b0, 0);
    chk("no_done_after_reset", dones - ld_d, 0);
    chk("no_write_after_reset", writes - ld_w, 0);
    chk("idle_after_reset", int'(busy), 0);

    // Fresh load from IDLE after reset.
    for (int k = 0; k < N; k++) vals[k] = Q - 1 - k;
    begin_load(1000);
    stream_rest(1'b0);
    finish_load();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
